// File: rtl/apb_alu_pkg.sv
// Shared types and constants for the APB ALU master: FSM encoding, response status codes and
// the address of the slaves' result register.
package apb_alu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWSetup,
    StWAccess,
    StRSetup,
    StRAccess,
    StResp
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_SLVERR  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_BADIDX  = 2'b11;

  localparam int unsigned RESULT_ADDR = 0;

endpackage

// File: rtl/apb_alu_master_timeout_cnt.sv
// Wait-state counter for APB access phases; flags the cycle whose stalled increment reaches
// TIMEOUT so the master can abort on that same edge.
module apb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntWidth = $clog2(TIMEOUT + 1);
  localparam logic [CntWidth-1:0] CntMax  = CntWidth'(TIMEOUT);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT - 1);

  logic [CntWidth-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != CntMax)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = en && (cnt_q == CntLast);

endmodule

// File: rtl/apb_alu_master.sv
// APB master that issues an opcode/operand write to one ALU slave, reads back its result
// register and returns result, accumulated PSLVERR and a status code on a valid/ready port.
module apb_alu_master
  import apb_alu_pkg::*;
#(
  parameter int unsigned SEL_WIDTH  = 3,
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IDX_WIDTH  = 2,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  i_PCLK,
  input  logic                  i_PRESET,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [IDX_WIDTH-1:0]  i_cmd_idx,
  input  logic [ADDR_WIDTH-1:0] i_cmd_op,
  input  logic [DATA_WIDTH-1:0] i_cmd_data,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic [3:0]            o_rsp_err,
  output logic [1:0]            o_rsp_status,
  output logic [SEL_WIDTH-1:0]  o_PSEL,
  output logic                  o_PENABLE,
  output logic                  o_PWRITE,
  output logic [ADDR_WIDTH-1:0] o_PADDR,
  output logic [DATA_WIDTH-1:0] o_PWDATA,
  input  logic                  i_PREADY,
  input  logic [DATA_WIDTH-1:0] i_PRDATA,
  input  logic [3:0]            i_PSLVERR
);

  localparam logic [SEL_WIDTH-1:0] SelOne   = SEL_WIDTH'(1);
  localparam logic [IDX_WIDTH:0]   SelLimit = (IDX_WIDTH + 1)'(SEL_WIDTH);

  state_t     state_q;
  logic [3:0] err_q;
  logic [3:0] err_final;
  logic       tmo_clear;
  logic       tmo_en;
  logic       tmo_expired;

  assign o_cmd_ready = (state_q == StIdle);
  assign tmo_clear   = (state_q == StWSetup) || (state_q == StRSetup);
  assign tmo_en      = ((state_q == StWAccess) || (state_q == StRAccess)) && !i_PREADY;
  assign err_final   = err_q | i_PSLVERR;

  apb_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_cnt (
    .clk     (i_PCLK),
    .rst     (i_PRESET),
    .clear   (tmo_clear),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge i_PCLK or posedge i_PRESET) begin
    if (i_PRESET) begin
      state_q      <= StIdle;
      err_q        <= '0;
      o_PSEL       <= '0;
      o_PENABLE    <= 1'b0;
      o_PWRITE     <= 1'b0;
      o_PADDR      <= '0;
      o_PWDATA     <= '0;
      o_rsp_valid  <= 1'b0;
      o_rsp_data   <= '0;
      o_rsp_err    <= '0;
      o_rsp_status <= ST_OK;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_cmd_valid) begin
            err_q <= '0;
            if ({1'b0, i_cmd_idx} < SelLimit) begin
              state_q  <= StWSetup;
              o_PSEL   <= SelOne << i_cmd_idx;
              o_PWRITE <= 1'b1;
              o_PADDR  <= i_cmd_op;
              o_PWDATA <= i_cmd_data;
            end else begin
              // Unmapped slave: answer immediately without touching the bus.
              state_q      <= StResp;
              o_rsp_valid  <= 1'b1;
              o_rsp_data   <= '0;
              o_rsp_err    <= '0;
              o_rsp_status <= ST_BADIDX;
            end
          end
        end
        StWSetup: begin
          state_q   <= StWAccess;
          o_PENABLE <= 1'b1;
        end
        StWAccess: begin
          if (i_PREADY) begin
            // PSEL stays up: the read follows back-to-back.
            state_q   <= StRSetup;
            err_q     <= i_PSLVERR;
            o_PENABLE <= 1'b0;
            o_PWRITE  <= 1'b0;
            o_PADDR   <= ADDR_WIDTH'(RESULT_ADDR);
            o_PWDATA  <= '0;
          end else if (tmo_expired) begin
            state_q      <= StResp;
            o_PSEL       <= '0;
            o_PENABLE    <= 1'b0;
            o_rsp_valid  <= 1'b1;
            o_rsp_data   <= '0;
            o_rsp_err    <= err_q;
            o_rsp_status <= ST_TIMEOUT;
          end
        end
        StRSetup: begin
          state_q   <= StRAccess;
          o_PENABLE <= 1'b1;
        end
        StRAccess: begin
          if (i_PREADY) begin
            state_q      <= StResp;
            o_PSEL       <= '0;
            o_PENABLE    <= 1'b0;
            o_rsp_valid  <= 1'b1;
            o_rsp_data   <= i_PRDATA;
            o_rsp_err    <= err_final;
            o_rsp_status <= (err_final != 4'd0) ? ST_SLVERR : ST_OK;
          end else if (tmo_expired) begin
            state_q      <= StResp;
            o_PSEL       <= '0;
            o_PENABLE    <= 1'b0;
            o_rsp_valid  <= 1'b1;
            o_rsp_data   <= '0;
            o_rsp_err    <= err_q;
            o_rsp_status <= ST_TIMEOUT;
          end
        end
        StResp: begin
          if (i_rsp_ready) begin
            state_q     <= StIdle;
            o_rsp_valid <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_alu_master.sv
// Directed bench for apb_alu_master with a behavioural, configurable APB slave.
module tb_apb_alu_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_idx = '0;
  logic [1:0] cmd_op = '0;
  logic [7:0] cmd_data = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic [3:0] rsp_err;
  logic [1:0] rsp_status;
  logic [2:0] psel;
  logic       penable;
  logic       pwrite;
  logic [1:0] paddr;
  logic [7:0] pwdata;
  logic       pready = 1'b0;
  logic [7:0] prdata = '0;
  logic [3:0] pslverr = '0;

  // Slave behaviour knobs
  int         waits = 0;
  bit         never_ready = 1'b0;
  logic [7:0] rdata = '0;
  logic [3:0] werr = '0;
  logic [3:0] rerr = '0;
  int         acc_cnt = 0;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  apb_alu_master #(
    .SEL_WIDTH (3),
    .ADDR_WIDTH(2),
    .DATA_WIDTH(8),
    .IDX_WIDTH (2),
    .TIMEOUT   (16)
  ) dut (
    .i_PCLK      (clk),
    .i_PRESET    (rst),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_idx   (cmd_idx),
    .i_cmd_op    (cmd_op),
    .i_cmd_data  (cmd_data),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_rsp_err   (rsp_err),
    .o_rsp_status(rsp_status),
    .o_PSEL      (psel),
    .o_PENABLE   (penable),
    .o_PWRITE    (pwrite),
    .o_PADDR     (paddr),
    .o_PWDATA    (pwdata),
    .i_PREADY    (pready),
    .i_PRDATA    (prdata),
    .i_PSLVERR   (pslverr)
  );

  // Slave answers on the falling edge so the master samples settled values.
  always @(negedge clk) begin
    if (psel != 3'b000 && penable && !never_ready) begin
      if (acc_cnt == waits) begin
        pready  <= 1'b1;
        prdata  <= pwrite ? 8'h00 : rdata;
        pslverr <= pwrite ? werr : rerr;
      end else begin
        pready  <= 1'b0;
        pslverr <= 4'h0;
      end
      acc_cnt <= acc_cnt + 1;
    end else begin
      pready  <= 1'b0;
      prdata  <= 8'h00;
      pslverr <= 4'h0;
      acc_cnt <= 0;
    end
  end

  // Issues one command and waits (bounded) for rsp_valid; lat counts edges from the accept edge.
  task automatic issue_cmd(input logic [1:0] idx, input logic [1:0] op, input logic [7:0] data,
                           output int lat, output int pen_w, output int pen_r,
                           output logic [2:0] psel_or, output int unstable);
    logic [2:0] p_psel;
    logic       p_wr;
    logic [1:0] p_addr;
    logic [7:0] p_wd;
    lat = 0; pen_w = 0; pen_r = 0; psel_or = '0; unstable = 0;
    p_psel = '0; p_wr = 1'b0; p_addr = '0; p_wd = '0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_idx = idx; cmd_op = op; cmd_data = data;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
      psel_or |= psel;
      if (penable) begin
        if (pwrite) pen_w++;
        else pen_r++;
        if (psel !== p_psel || pwrite !== p_wr || paddr !== p_addr || pwdata !== p_wd)
          unstable++;
      end
      p_psel = psel; p_wr = pwrite; p_addr = paddr; p_wd = pwdata;
      @(posedge clk);
      lat++;
    end
    if (!rsp_valid) lat = -1;
  endtask

  task automatic ack_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_tests++;
    if ({psel, penable, pwrite, paddr, pwdata} !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_bus: got %h, want 0", {psel, penable, pwrite, paddr, pwdata});
    end
    n_tests++;
    if ({cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_status} !== 16'h8000) begin
      n_fail++;
      $display("FAIL reset_rsp: got %h, want 8000",
               {cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_status});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    waits = 0; rdata = 8'h34; werr = 4'h0; rerr = 4'h0; never_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL zw_cmd_ready: got %b, want 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_idx = 2'd0; cmd_op = 2'b01; cmd_data = 8'h1A;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({psel, penable, pwrite, paddr, pwdata} !== {3'b001, 1'b0, 1'b1, 2'b01, 8'h1A}) begin
      n_fail++; $display("FAIL zw_w_setup: got %h, want %h", {psel, penable, pwrite, paddr, pwdata},
                         {3'b001, 1'b0, 1'b1, 2'b01, 8'h1A});
    end
    @(negedge clk);
    n_tests++;
    if ({psel, penable, pwrite, paddr, pwdata} !== {3'b001, 1'b1, 1'b1, 2'b01, 8'h1A}) begin
      n_fail++; $display("FAIL zw_w_access: got %h, want %h", {psel, penable, pwrite, paddr, pwdata},
                         {3'b001, 1'b1, 1'b1, 2'b01, 8'h1A});
    end
    @(negedge clk);
    n_tests++;
    if ({psel, penable, pwrite, paddr, pwdata} !== {3'b001, 1'b0, 1'b0, 2'b00, 8'h00}) begin
      n_fail++; $display("FAIL zw_r_setup: got %h, want %h", {psel, penable, pwrite, paddr, pwdata},
                         {3'b001, 1'b0, 1'b0, 2'b00, 8'h00});
    end
    @(negedge clk);
    n_tests++;
    if ({psel, penable, pwrite, rsp_valid} !== {3'b001, 1'b1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL zw_r_access: got %h, want %h", {psel, penable, pwrite, rsp_valid},
                         {3'b001, 1'b1, 1'b0, 1'b0});
    end
    @(negedge clk);
    n_tests++;
    if ({rsp_valid, rsp_data, rsp_status, rsp_err, psel, penable} !== {1'b1, 8'h34, 2'b00, 4'h0,
        3'b000, 1'b0}) begin
      n_fail++; $display("FAIL zw_resp: got %h, want %h",
                         {rsp_valid, rsp_data, rsp_status, rsp_err, psel, penable},
                         {1'b1, 8'h34, 2'b00, 4'h0, 3'b000, 1'b0});
    end
    ack_rsp();
  endtask

  task automatic test_wait_states();
    int lat, pw, pr, unst;
    logic [2:0] po;
    waits = 3; rdata = 8'hC3;
    issue_cmd(2'd2, 2'b11, 8'h0A, lat, pw, pr, po, unst);
    n_tests++;
    if (lat != 11) begin n_fail++; $display("FAIL ws_latency: got %0d, want 11", lat); end
    n_tests++;
    if (pw != 4 || pr != 4) begin
      n_fail++; $display("FAIL ws_penable_cycles: got w=%0d r=%0d, want 4/4", pw, pr);
    end
    n_tests++;
    if (po !== 3'b100) begin n_fail++; $display("FAIL ws_psel: got %b, want 100", po); end
    n_tests++;
    if (unst != 0) begin n_fail++; $display("FAIL ws_stable: got %0d changes, want 0", unst); end
    n_tests++;
    if ({rsp_data, rsp_status, rsp_err} !== {8'hC3, 2'b00, 4'h0}) begin
      n_fail++; $display("FAIL ws_resp: got %h, want %h", {rsp_data, rsp_status, rsp_err},
                         {8'hC3, 2'b00, 4'h0});
    end
    ack_rsp();
    waits = 0;
  endtask

  task automatic test_slverr();
    int lat, pw, pr, unst;
    logic [2:0] po;
    werr = 4'h2; rerr = 4'h4; rdata = 8'h77;
    issue_cmd(2'd1, 2'b10, 8'h33, lat, pw, pr, po, unst);
    n_tests++;
    if (rsp_err !== 4'h6) begin n_fail++; $display("FAIL se_err: got %h, want 6", rsp_err); end
    n_tests++;
    if (rsp_status !== 2'b01) begin
      n_fail++; $display("FAIL se_status: got %b, want 01", rsp_status);
    end
    n_tests++;
    if (rsp_data !== 8'h77 || lat != 5 || po !== 3'b010) begin
      n_fail++; $display("FAIL se_data: got data=%h lat=%0d psel=%b, want 77/5/010",
                         rsp_data, lat, po);
    end
    ack_rsp();
    werr = 4'h0; rerr = 4'h0;
  endtask

  task automatic test_bad_index();
    int lat, pw, pr, unst, bad;
    logic [2:0] po;
    issue_cmd(2'd3, 2'b01, 8'hEE, lat, pw, pr, po, unst);
    n_tests++;
    if (lat != 1) begin n_fail++; $display("FAIL bi_latency: got %0d, want 1", lat); end
    n_tests++;
    if ({rsp_status, rsp_err, rsp_data} !== {2'b11, 4'h0, 8'h00}) begin
      n_fail++; $display("FAIL bi_resp: got %h, want %h", {rsp_status, rsp_err, rsp_data},
                         {2'b11, 4'h0, 8'h00});
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_status !== 2'b11 || rsp_err !== 4'h0 || rsp_data !== 8'h00 ||
          cmd_ready !== 1'b0 || psel !== 3'b000 || penable !== 1'b0)
        bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL bi_hold: got %0d bad cycles, want 0", bad); end
    ack_rsp();
    @(negedge clk);
    n_tests++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      n_fail++; $display("FAIL bi_release: got %b, want 01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_timeout();
    int lat, pw, pr, unst;
    logic [2:0] po;
    never_ready = 1'b1;
    issue_cmd(2'd1, 2'b10, 8'h55, lat, pw, pr, po, unst);
    n_tests++;
    if (lat != 18) begin n_fail++; $display("FAIL to_latency: got %0d, want 18", lat); end
    n_tests++;
    if (pw != 16 || pr != 0) begin
      n_fail++; $display("FAIL to_penable_cycles: got w=%0d r=%0d, want 16/0", pw, pr);
    end
    n_tests++;
    if ({rsp_status, rsp_data, rsp_err, psel, penable} !== {2'b10, 8'h00, 4'h0, 3'b000, 1'b0})
    begin
      n_fail++; $display("FAIL to_resp: got %h, want %h",
                         {rsp_status, rsp_data, rsp_err, psel, penable},
                         {2'b10, 8'h00, 4'h0, 3'b000, 1'b0});
    end
    ack_rsp();
    never_ready = 1'b0; waits = 0; rdata = 8'h5A;
    issue_cmd(2'd1, 2'b01, 8'h11, lat, pw, pr, po, unst);
    n_tests++;
    if (lat != 5 || rsp_status !== 2'b00 || rsp_data !== 8'h5A) begin
      n_fail++; $display("FAIL to_recover: got lat=%0d status=%b data=%h, want 5/00/5a",
                         lat, rsp_status, rsp_data);
    end
    ack_rsp();
  endtask

  task automatic test_reset_mid();
    int lat, pw, pr, unst;
    logic [2:0] po;
    waits = 5;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_idx = 2'd0; cmd_op = 2'b01; cmd_data = 8'hAA;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({psel, penable} !== 4'b0011) begin
      n_fail++; $display("FAIL rm_in_access: got %b, want 0011", {psel, penable});
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({psel, penable, pwrite, paddr, pwdata, rsp_valid} !== 16'h0) begin
      n_fail++; $display("FAIL rm_async_clear: got %h, want 0",
                         {psel, penable, pwrite, paddr, pwdata, rsp_valid});
    end
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready: got %b, want 1", cmd_ready); end
    waits = 0; rdata = 8'h21;
    issue_cmd(2'd0, 2'b10, 8'h44, lat, pw, pr, po, unst);
    n_tests++;
    if (lat != 5 || rsp_status !== 2'b00 || rsp_data !== 8'h21) begin
      n_fail++; $display("FAIL rm_fresh_cmd: got lat=%0d status=%b data=%h, want 5/00/21",
                         lat, rsp_status, rsp_data);
    end
    ack_rsp();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_slverr();
    test_bad_index();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
